// File: rtl/serial_add_unit.sv
// Bit-serial adder/subtractor: one full_adder cell, one bit per clock, LSB first.
// Operands are accepted through a start/done handshake; results hold until the next done.

module full_adder (
   input  logic a,
   input  logic b,
   input  logic ci,
   output logic s,
   output logic co
);
   assign s  = a ^ b ^ ci;
   assign co = (a & b) | (ci & (a ^ b));
endmodule

module serial_add_unit #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             sub,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] result,
   output logic             cout,
   output logic             overflow,
   output logic             zero
);
   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t           state, nstate;
   logic [WIDTH-1:0] a_sh, b_sh, acc_sh;
   logic [CW-1:0]    cnt;
   logic             carry;
   logic             fa_s, fa_co;
   logic             accept, last;
   logic             c_msb;
   logic [WIDTH-1:0] acc_final;

   full_adder u_fa (
      .a  (a_sh[0]),
      .b  (b_sh[0]),
      .ci (carry),
      .s  (fa_s),
      .co (fa_co)
   );

   assign accept    = start && (state != RUN);
   assign last      = (state == RUN) && (cnt == LAST);
   // On the last bit the registered carry is the carry into the MSB.
   assign c_msb     = carry;
   assign acc_final = {fa_s, acc_sh[WIDTH-1:1]};

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= nstate;
   end

   always_comb begin
      nstate = state;
      case (state)
         IDLE:    if (start) nstate = RUN;
         RUN:     if (cnt == LAST) nstate = DONE;
         DONE:    nstate = start ? RUN : IDLE;
         default: nstate = IDLE;
      endcase
   end

   always_comb begin
      busy = (state == RUN);
      done = (state == DONE);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         a_sh     <= '0;
         b_sh     <= '0;
         acc_sh   <= '0;
         carry    <= 1'b0;
         cnt      <= '0;
         result   <= '0;
         cout     <= 1'b0;
         overflow <= 1'b0;
         zero     <= 1'b0;
      end else begin
         if (accept) begin
            a_sh   <= a;
            b_sh   <= sub ? ~b : b;
            carry  <= sub;
            cnt    <= '0;
            acc_sh <= '0;
         end else if (state == RUN) begin
            a_sh   <= {1'b0, a_sh[WIDTH-1:1]};
            b_sh   <= {1'b0, b_sh[WIDTH-1:1]};
            acc_sh <= acc_final;
            carry  <= fa_co;
            cnt    <= cnt + 1'b1;
         end
         if (last) begin
            result   <= acc_final;
            cout     <= fa_co;
            overflow <= c_msb ^ fa_co;
            zero     <= (acc_final == '0);
         end
      end
   end
endmodule

// File: tb/tb_serial_add_unit.sv
// Directed bench for serial_add_unit (WIDTH=8): latency, arithmetic, flags,
// ignored mid-run start, back-to-back starts and mid-run reset.

module tb_serial_add_unit;
   logic       clk = 1'b0;
   logic       rst, start, sub;
   logic [7:0] a, b;
   logic       busy, done, cout, overflow, zero;
   logic [7:0] result;

   int checks = 0;
   int errors = 0;

   serial_add_unit #(.WIDTH(8)) dut (
      .clk(clk), .rst(rst), .start(start), .sub(sub), .a(a), .b(b),
      .busy(busy), .done(done), .result(result), .cout(cout),
      .overflow(overflow), .zero(zero)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Runs one op from IDLE; checks latency, busy window, held outputs and results.
   task automatic op(input string tag, input logic s, input logic [7:0] av, input logic [7:0] bv,
                     input logic [7:0] er, input logic ec, input logic eo, input logic ez);
      int n, nbusy;
      logic held;
      logic [7:0] prev;
      prev = result;
      held = 1'b1;
      start = 1'b1; sub = s; a = av; b = bv;
      tick();
      start = 1'b0;
      n = 1; nbusy = 0;
      while (!done && n < 30) begin
         if (busy) nbusy++;
         if (result !== prev) held = 1'b0;
         tick();
         n++;
      end
      chk({tag, " latency"}, n, 9);
      chk({tag, " busy_cycles"}, nbusy, 8);
      chk({tag, " held"}, held, 1);
      chk({tag, " result"}, result, er);
      chk({tag, " cout"}, cout, ec);
      chk({tag, " overflow"}, overflow, eo);
      chk({tag, " zero"}, zero, ez);
      chk({tag, " busy_at_done"}, busy, 0);
      tick();
      chk({tag, " done_one_cycle"}, done, 0);
   endtask

   initial begin
      int n, ndone, last_done;
      logic [7:0] qa [4], qb [4], qr [4];
      logic       qs [4], qc [4];

      rst = 1'b1; start = 1'b0; sub = 1'b0; a = '0; b = '0;
      tick(); tick();
      rst = 1'b0;
      chk("reset busy", busy, 0);
      chk("reset done", done, 0);
      chk("reset result", result, 0);
      chk("reset flags", {cout, overflow, zero}, 0);

      op("add100+27", 0, 8'd100, 8'd27, 8'd127, 0, 0, 0);
      op("add200+100", 0, 8'd200, 8'd100, 8'd44, 1, 0, 0);
      op("add127+1", 0, 8'd127, 8'd1, 8'd128, 0, 1, 0);
      op("sub5-5", 1, 8'd5, 8'd5, 8'd0, 1, 0, 1);
      op("sub3-5", 1, 8'd3, 8'd5, 8'd254, 0, 0, 0);
      op("sub128-1", 1, 8'd128, 8'd1, 8'd127, 1, 1, 0);
      op("add1+2", 0, 8'd1, 8'd2, 8'd3, 0, 0, 0);

      // start pulsed mid-run with different operands must be ignored
      start = 1'b1; sub = 1'b0; a = 8'd100; b = 8'd27;
      tick(); start = 1'b0;
      n = 1; ndone = 0;
      while (n < 20) begin
         if (n == 4) begin start = 1'b1; a = 8'd1; b = 8'd1; end
         else start = 1'b0;
         if (done) begin
            ndone++;
            if (ndone == 1) begin
               chk("ignore latency", n, 9);
               chk("ignore result", result, 127);
            end
         end
         tick();
         n++;
      end
      chk("ignore single_done", ndone, 1);

      // start held high: new operands presented in each DONE cycle
      qa = '{8'd10, 8'd50, 8'd255, 8'd0};
      qb = '{8'd20, 8'd7, 8'd255, 8'd1};
      qs = '{1'b0, 1'b1, 1'b0, 1'b1};
      qr = '{8'd30, 8'd43, 8'd254, 8'd255};
      qc = '{1'b0, 1'b1, 1'b1, 1'b0};
      start = 1'b1; sub = qs[0]; a = qa[0]; b = qb[0];
      tick();
      n = 1; ndone = 0; last_done = 0;
      while (ndone < 4 && n < 60) begin
         if (done) begin
            chk($sformatf("b2b%0d interval", ndone), n - last_done, 9);
            chk($sformatf("b2b%0d result", ndone), result, qr[ndone]);
            chk($sformatf("b2b%0d cout", ndone), cout, qc[ndone]);
            last_done = n;
            ndone++;
            if (ndone < 4) begin sub = qs[ndone]; a = qa[ndone]; b = qb[ndone]; end
            else start = 1'b0;
         end
         tick();
         n++;
      end
      chk("b2b count", ndone, 4);
      start = 1'b0;
      tick();

      // reset in cycle 5 of an op
      start = 1'b1; sub = 1'b0; a = 8'd100; b = 8'd27;
      tick(); start = 1'b0;
      repeat (4) tick();
      chk("rst busy_before", busy, 1);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("rst busy", busy, 0);
      chk("rst done", done, 0);
      chk("rst result", result, 0);
      chk("rst flags", {cout, overflow, zero}, 0);
      ndone = 0;
      repeat (12) begin
         if (done) ndone++;
         tick();
      end
      chk("rst no_done", ndone, 0);
      op("post_rst 100+27", 0, 8'd100, 8'd27, 8'd127, 0, 0, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
